// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM states and parity mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_TIME-1 and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int BIT_TIME = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(BIT_TIME - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_TIME  = 10416,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 tx_rdy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 timer_clr;

  assign timer_clr = (state_q == ST_IDLE);

  uart_bit_timer #(
    .BIT_TIME (BIT_TIME)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load && rdy_q) begin
          shift_d    = din;
          parity_d   = (PARITY == PAR_ODD) ? ~(^din) : ^din;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so tx changes on the same edge as the FSM.
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
    end
  end

  assign tx     = tx_q;
  assign tx_rdy = rdy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations checked cycle-by-cycle against a frame model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] load;
  logic [7:0] din [4];
  logic [3:0] tx, rdy, done_v;

  int bt [4] = '{4, 4, 4, 3};
  int db [4] = '{8, 8, 8, 5};
  int pm [4] = '{0, 1, 2, 0};
  int sb [4] = '{1, 1, 2, 1};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.BIT_TIME(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .load(load[0]), .din(din[0]),
    .tx(tx[0]), .tx_rdy(rdy[0]), .done(done_v[0]));
  uart_tx #(.BIT_TIME(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load[1]), .din(din[1]),
    .tx(tx[1]), .tx_rdy(rdy[1]), .done(done_v[1]));
  uart_tx #(.BIT_TIME(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .load(load[2]), .din(din[2]),
    .tx(tx[2]), .tx_rdy(rdy[2]), .done(done_v[2]));
  uart_tx #(.BIT_TIME(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .clk(clk), .rst(rst), .load(load[3]), .din(din[3][4:0]),
    .tx(tx[3]), .tx_rdy(rdy[3]), .done(done_v[3]));

  task automatic check_eq(input string tag, input int k, input logic [7:0] got,
                          input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", tag, k, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check_eq({tag, "_tx"}, k, 8'(tx[k]), 8'd1);
    check_eq({tag, "_rdy"}, k, 8'(rdy[k]), 8'd1);
    check_eq({tag, "_done"}, k, 8'(done_v[k]), 8'd0);
  endtask

  // Entered just after a negedge with load[k]=1 and din[k]=data already driven.
  task automatic run_frame(input int k, input logic [7:0] data, input bit chain,
                           input logic [7:0] nxt, input int busy_at, input int rst_at);
    logic       exp_bits [$];
    logic [7:0] m;
    logic       par;
    int         f;
    m = data & 8'((1 << db[k]) - 1);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < db[k]; i++) exp_bits.push_back(m[i]);
    par = ^m;
    if (pm[k] == 2) par = ~par;
    if (pm[k] != 0) exp_bits.push_back(par);
    for (int i = 0; i < sb[k]; i++) exp_bits.push_back(1'b1);
    f = bt[k] * exp_bits.size();
    check_eq("rdy_at_load", k, 8'(rdy[k]), 8'd1);
    for (int c = 1; c <= f + 1; c++) begin
      @(negedge clk);
      if (c <= f) begin
        check_eq($sformatf("tx_c%0d", c), k, 8'(tx[k]), 8'(exp_bits[(c - 1) / bt[k]]));
        check_eq($sformatf("rdy_c%0d", c), k, 8'(rdy[k]), 8'd0);
        check_eq($sformatf("done_c%0d", c), k, 8'(done_v[k]), 8'd0);
      end else begin
        check_eq("end_tx", k, 8'(tx[k]), 8'd1);
        check_eq("end_rdy", k, 8'(rdy[k]), 8'd1);
        check_eq("end_done", k, 8'(done_v[k]), 8'd1);
      end
      if (c == rst_at) begin
        load[k] = 1'b0;
        rst = 1'b1;
        #1;
        check_idle(k, "rst_async");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c == 1) begin
        load[k] = chain;
        din[k]  = chain ? nxt : 8'($urandom);
      end
      if (busy_at > 1 && c == busy_at) begin
        load[k] = 1'b1;
        din[k]  = 8'h3C;
      end
      if (busy_at > 1 && c == busy_at + 1) begin
        load[k] = chain;
        din[k]  = chain ? nxt : 8'($urandom);
      end
    end
  endtask

  task automatic send(input int k, input logic [7:0] data, input int busy_at, input int rst_at);
    load[k] = 1'b1;
    din[k]  = data;
    run_frame(k, data, 1'b0, 8'h00, busy_at, rst_at);
    if (rst_at == 0) begin
      @(negedge clk);
      check_idle(k, "post");
    end
  endtask

  task automatic send_chain(input int k, input logic [7:0] d1, input logic [7:0] d2);
    load[k] = 1'b1;
    din[k]  = d1;
    run_frame(k, d1, 1'b1, d2, 0, 0);
    run_frame(k, d2, 1'b0, 8'h00, 0, 0);
    @(negedge clk);
    check_idle(k, "post_chain");
  endtask

  initial begin
    rst  = 1'b1;
    load = '0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) check_idle(k, "reset");
    rst = 1'b0;
    @(negedge clk);

    send(0, 8'hA5, 0, 0);
    send(0, 8'hA5, 14, 0);          // mid-frame load of 0x3C must be ignored
    send(0, 8'hC3, 0, 18);          // reset during data bit 3
    check_idle(0, "after_rst");
    send(0, 8'h55, 0, 0);

    send_chain(1, 8'hA5, 8'h07);
    send_chain(2, 8'hA5, 8'h07);
    send(2, 8'h07, 9, 0);
    send(3, 8'hFF, 0, 0);           // only the low 5 bits reach the line
    send_chain(3, 8'hE0, 8'h3A);

    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 1) == 1)
          send_chain(k, 8'($urandom), 8'($urandom));
        else
          send(k, 8'($urandom), int'($urandom_range(2, 20)), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the outbound counterpart of the receive path in the same UART. Accepts one byte per load handshake from the host side and drives the asynchronous `tx` line with one frame: start bit, data bits LSB first, optional parity, and one or two stop bits. Bit timing is derived internally from `clk` using a fixed cycle count per bit.

## Interface
- `BIT_TIME`, default 10416: clk cycles per serial bit (100 MHz / 9600 baud). Must be at least 2.
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `PARITY`, default 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `load` in 1: request to send `din`; sampled only while `tx_rdy`=1.
- `din` in DATA_BITS: byte to send; captured on the accepted `load` cycle.
- `tx` out 1: serial line, idle high; registered.
- `tx_rdy` out 1: high when a new `load` will be accepted.
- `done` out 1: one-cycle pulse at end of the frame's last stop bit.

## Operation
- Reset values: `tx`=1, `tx_rdy`=1, `done`=0, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame immediately; `tx` returns high asynchronously. No partial frame resumes.
- FSM states:
  - IDLE: on `load`&`tx_rdy`, latch `din` into the shift register, compute parity, clear timer, go START.
  - START: `tx`=0 for BIT_TIME cycles, then go DATA with bit index 0.
  - DATA: `tx`=shift[0]; at end of bit shift right and increment index. After bit DATA_BITS-1, go PARITY if PARITY≠0, else STOP.
  - PARITY: `tx`=parity bit for BIT_TIME cycles, then go STOP.
  - STOP: `tx`=1 for STOP_BITS×BIT_TIME cycles, then go IDLE, pulse `done`, raise `tx_rdy`.
- Parity is computed once, at load, from the latched byte. Even: XOR of data bits. Odd: inverted XOR.
- Bit timer counts 0..BIT_TIME-1 and is $clog2(BIT_TIME) bits wide. The end-of-bit tick occurs at BIT_TIME-1, and the timer wraps to 0 on the tick.
- `load` while `tx_rdy`=0 is ignored without error. `din` is don't-care except on the accepted cycle.
- Invalid state encodings go to IDLE with `tx`=1.

## Timing
- An accepted `load` at edge N gives `tx_rdy`=0 and `tx`=0 (start bit) from edge N+1.
- Frame length F = BIT_TIME × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles. `tx` is held constant for exactly BIT_TIME cycles per bit.
- `done`=1 and `tx_rdy`=1 both appear from edge N+1+F. `done` lasts one cycle.
- A `load` accepted in the cycle `tx_rdy` returns high starts the next start bit on the following edge. Back-to-back frames therefore have no idle gap beyond the stop bits.
- `tx_rdy` and `done` are registered; there is no combinational path from `load` to any output.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP) and parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD. The receiver shares these constants.
- One sub-module, `uart_bit_timer`: parameter BIT_TIME; inputs `clk`, `rst`, `clr`; output `tick`, asserted at the last cycle of each bit. The baud-tick logic on the receive side reuses it.
- The top level holds the FSM, shift register, bit index counter, stop-bit counter and output registers.

## Test plan
- BIT_TIME=4, no parity, 1 stop, load 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `done` pulses at 40 cycles after the load edge, and `tx_rdy` rises in the same cycle.
- Even parity, load 0xA5 then 0x07 → parity bits 0 then 1. With odd parity → 1 then 0. Frame length is 44 cycles each.
- STOP_BITS=2: stop level held 8 cycles. Hold `load` high continuously → second frame's start bit begins the cycle after `done`, with no extra idle cycles.
- Pulse `load` with 0x3C while busy, mid-frame → ignored. Transmitted data is the original byte, and only one `done` pulse occurs.
- Assert `rst` during DATA bit 3 → `tx`=1 immediately, `tx_rdy`=1, `done`=0. After release, a new load of 0x55 transmits a complete, correct frame.
- DATA_BITS=5, load 0x1F with upper bits garbage → exactly 5 data bits sent, then stop. Frame length is 7×BIT_TIME.
